// File: rtl/imm_decode_ctrl.sv
// rtl/imm_decode_ctrl.sv - decode-stage controller: classifies opcodes into immediate-select codes
// and holds one instruction for the immediate generator and execute, trapping illegal encodings.
module imm_decode_ctrl #(
  parameter int WIDTH_INST_LENGTH = 32,
  parameter int WIDTH_SEL_LENGTH  = 3
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [WIDTH_INST_LENGTH-1:0] InInst,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic                         Flush,
  input  logic                         OutReady,
  output logic                         OutValid,
  output logic [WIDTH_INST_LENGTH-1:0] Inst,
  output logic [WIDTH_SEL_LENGTH-1:0]  ImmSel,
  output logic                         UsesImm,
  output logic                         Trap,
  output logic [WIDTH_INST_LENGTH-1:0] TrapInst
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [6:0]                  opcode;
  logic [2:0]                  funct3;
  logic [6:0]                  funct7;
  logic [WIDTH_SEL_LENGTH-1:0] dec_sel;
  logic                        dec_uses;
  logic                        dec_illegal;
  logic                        accept;
  logic                        load_legal;
  logic                        load_illegal;

  assign opcode = InInst[6:0];
  assign funct3 = InInst[14:12];
  assign funct7 = InInst[31:25];

  always_comb begin
    dec_sel     = 3'b111;
    dec_uses    = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec_sel  = 3'b000;
        dec_uses = 1'b1;
      end
      7'b0010011: begin
        dec_uses = 1'b1;
        if (funct3 == 3'b001) begin
          dec_sel     = 3'b010;
          dec_illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_sel     = 3'b010;
          dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end else begin
          dec_sel = 3'b000;
        end
      end
      7'b0100011: begin
        dec_sel  = 3'b011;
        dec_uses = 1'b1;
      end
      7'b1100011: begin
        dec_sel     = 3'b100;
        dec_uses    = 1'b1;
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      7'b0110111, 7'b0010111: begin
        dec_sel  = 3'b101;
        dec_uses = 1'b1;
      end
      7'b1101111: begin
        dec_sel  = 3'b110;
        dec_uses = 1'b1;
      end
      7'b1110011: begin
        // CSR forms carry the CSR address in the immediate field; ECALL/EBREAK carry none
        if (funct3 != 3'b000) begin
          dec_sel  = 3'b001;
          dec_uses = 1'b1;
        end
      end
      7'b0110011, 7'b0001111: begin
        dec_sel  = 3'b111;
        dec_uses = 1'b0;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (InInst[1:0] != 2'b11) dec_illegal = 1'b1;
  end

  assign InReady      = !Flush && ((state == EMPTY) || ((state == VALID) && OutReady));
  assign accept       = InValid && InReady;
  assign load_legal   = accept && !dec_illegal;
  assign load_illegal = accept && dec_illegal;

  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = dec_illegal ? TRAP : VALID;
        VALID: begin
          if (OutReady) begin
            if (accept) state_nxt = dec_illegal ? TRAP : VALID;
            else        state_nxt = EMPTY;
          end
        end
        TRAP:    state_nxt = TRAP;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= EMPTY;
      Inst     <= '0;
      ImmSel   <= '1;
      UsesImm  <= 1'b0;
      TrapInst <= '0;
    end else begin
      state <= state_nxt;
      if (load_legal) begin
        Inst    <= InInst;
        ImmSel  <= dec_sel;
        UsesImm <= dec_uses;
      end
      if (Flush)             TrapInst <= '0;
      else if (load_illegal) TrapInst <= InInst;
    end
  end

  assign OutValid = (state == VALID);
  assign Trap     = (state == TRAP);

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb/tb_imm_decode_ctrl.sv - directed-vector bench for imm_decode_ctrl.
module tb_imm_decode_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] InInst;
  logic        InValid;
  logic        InReady;
  logic        Flush;
  logic        OutReady;
  logic        OutValid;
  logic [31:0] Inst;
  logic [2:0]  ImmSel;
  logic        UsesImm;
  logic        Trap;
  logic [31:0] TrapInst;

  int vectors;
  int miscompares;

  imm_decode_ctrl #(.WIDTH_INST_LENGTH(32), .WIDTH_SEL_LENGTH(3)) dut (
    .Clk(Clk), .Rst(Rst), .InInst(InInst), .InValid(InValid), .InReady(InReady),
    .Flush(Flush), .OutReady(OutReady), .OutValid(OutValid), .Inst(Inst),
    .ImmSel(ImmSel), .UsesImm(UsesImm), .Trap(Trap), .TrapInst(TrapInst)
  );

  always #5 Clk = ~Clk;

  task automatic test_reset();
    Rst = 1'b1; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0; InInst = 32'h0;
    #12;
    vectors++; if (OutValid !== 1'b0)    begin miscompares++; $display("FAIL rst_outvalid got %b want 0", OutValid); end
    vectors++; if (Trap !== 1'b0)        begin miscompares++; $display("FAIL rst_trap got %b want 0", Trap); end
    vectors++; if (Inst !== 32'h0)       begin miscompares++; $display("FAIL rst_inst got %h want 0", Inst); end
    vectors++; if (TrapInst !== 32'h0)   begin miscompares++; $display("FAIL rst_trapinst got %h want 0", TrapInst); end
    vectors++; if (ImmSel !== 3'b111)    begin miscompares++; $display("FAIL rst_immsel got %b want 111", ImmSel); end
    vectors++; if (UsesImm !== 1'b0)     begin miscompares++; $display("FAIL rst_usesimm got %b want 0", UsesImm); end
    @(negedge Clk); Rst = 1'b0; #1;
    vectors++; if (InReady !== 1'b1)     begin miscompares++; $display("FAIL rst_inready got %b want 1", InReady); end
  endtask

  // back-to-back stream with OutReady held high: one instruction per cycle
  task automatic test_stream();
    logic [31:0] v [10];
    logic [2:0]  s [10];
    logic        u [10];
    v = '{32'h00500093, 32'h00209113, 32'h00112223, 32'hFE000EE3, 32'h123452B7,
          32'h0000006F, 32'h30002573, 32'h40005013, 32'h0000000F, 32'h00000073};
    s = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b010, 3'b111, 3'b111};
    u = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge Clk);
    OutReady = 1'b1; InValid = 1'b1; InInst = v[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      vectors++; if (OutValid !== 1'b1) begin miscompares++; $display("FAIL stream%0d_outvalid got %b want 1", i, OutValid); end
      vectors++; if (Inst !== v[i])     begin miscompares++; $display("FAIL stream%0d_inst got %h want %h", i, Inst, v[i]); end
      vectors++; if (ImmSel !== s[i])   begin miscompares++; $display("FAIL stream%0d_immsel got %b want %b", i, ImmSel, s[i]); end
      vectors++; if (UsesImm !== u[i])  begin miscompares++; $display("FAIL stream%0d_usesimm got %b want %b", i, UsesImm, u[i]); end
      if (i < 9) InInst = v[i+1];
      else       InValid = 1'b0;
    end
    @(negedge Clk);
    vectors++; if (OutValid !== 1'b0)     begin miscompares++; $display("FAIL stream_drain_outvalid got %b want 0", OutValid); end
    vectors++; if (Inst !== 32'h00000073) begin miscompares++; $display("FAIL stream_drain_inst got %h want 00000073", Inst); end
  endtask

  task automatic test_backpressure();
    @(negedge Clk);
    OutReady = 1'b0; InValid = 1'b1; InInst = 32'h00B50533;
    @(negedge Clk);
    InInst = 32'h00500093;
    #1;
    vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL bp_inready got %b want 0", InReady); end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      vectors++; if (OutValid !== 1'b1)     begin miscompares++; $display("FAIL bp%0d_outvalid got %b want 1", i, OutValid); end
      vectors++; if (Inst !== 32'h00B50533) begin miscompares++; $display("FAIL bp%0d_inst got %h want 00b50533", i, Inst); end
      vectors++; if (ImmSel !== 3'b111)     begin miscompares++; $display("FAIL bp%0d_immsel got %b want 111", i, ImmSel); end
      vectors++; if (UsesImm !== 1'b0)      begin miscompares++; $display("FAIL bp%0d_usesimm got %b want 0", i, UsesImm); end
      vectors++; if (InReady !== 1'b0)      begin miscompares++; $display("FAIL bp%0d_inready got %b want 0", i, InReady); end
    end
    OutReady = 1'b1;
    #1;
    vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL bp_release_inready got %b want 1", InReady); end
    @(negedge Clk);
    InValid = 1'b0;
    vectors++; if (Inst !== 32'h00500093) begin miscompares++; $display("FAIL bp_next_inst got %h want 00500093", Inst); end
    vectors++; if (ImmSel !== 3'b000)     begin miscompares++; $display("FAIL bp_next_immsel got %b want 000", ImmSel); end
    vectors++; if (OutValid !== 1'b1)     begin miscompares++; $display("FAIL bp_next_outvalid got %b want 1", OutValid); end
    @(negedge Clk);
    vectors++; if (OutValid !== 1'b0)     begin miscompares++; $display("FAIL bp_drain_outvalid got %b want 0", OutValid); end
  endtask

  // first entry reaches TRAP from VALID (preceded by a legal ADDI), the rest from EMPTY
  task automatic test_trap();
    logic [31:0] bad [5];
    bad = '{32'h40209113, 32'h00000001, 32'h00002063, 32'h00000007, 32'h80005013};
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      OutReady = 1'b1; InValid = 1'b1;
      if (i == 0) begin
        InInst = 32'h00500093;
        @(negedge Clk);
      end
      InInst = bad[i];
      @(negedge Clk);
      InInst = 32'h00112223;
      #1;
      vectors++; if (Trap !== 1'b1)       begin miscompares++; $display("FAIL trap%0d_trap got %b want 1", i, Trap); end
      vectors++; if (TrapInst !== bad[i]) begin miscompares++; $display("FAIL trap%0d_trapinst got %h want %h", i, TrapInst, bad[i]); end
      vectors++; if (OutValid !== 1'b0)   begin miscompares++; $display("FAIL trap%0d_outvalid got %b want 0", i, OutValid); end
      vectors++; if (InReady !== 1'b0)    begin miscompares++; $display("FAIL trap%0d_inready got %b want 0", i, InReady); end
      vectors++; if (Inst !== 32'h00500093) begin miscompares++; $display("FAIL trap%0d_inst got %h want 00500093", i, Inst); end
      repeat (3) @(negedge Clk);
      vectors++; if (Trap !== 1'b1 || InReady !== 1'b0 || OutValid !== 1'b0) begin
        miscompares++; $display("FAIL trap%0d_frozen trap=%b inready=%b outvalid=%b want 1 0 0", i, Trap, InReady, OutValid);
      end
      Flush = 1'b1; InValid = 1'b0;
      @(negedge Clk);
      Flush = 1'b0;
      #1;
      vectors++; if (Trap !== 1'b0)     begin miscompares++; $display("FAIL flush%0d_trap got %b want 0", i, Trap); end
      vectors++; if (TrapInst !== 32'h0) begin miscompares++; $display("FAIL flush%0d_trapinst got %h want 0", i, TrapInst); end
      vectors++; if (InReady !== 1'b1)  begin miscompares++; $display("FAIL flush%0d_inready got %b want 1", i, InReady); end
      vectors++; if (OutValid !== 1'b0) begin miscompares++; $display("FAIL flush%0d_outvalid got %b want 0", i, OutValid); end
    end
  endtask

  task automatic test_flush_same_cycle();
    @(negedge Clk);
    OutReady = 1'b0; InValid = 1'b1; InInst = 32'h00B50533;
    @(negedge Clk);
    vectors++; if (OutValid !== 1'b1) begin miscompares++; $display("FAIL fsc_setup_outvalid got %b want 1", OutValid); end
    Flush = 1'b1; OutReady = 1'b1; InInst = 32'h123452B7;
    #1;
    vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL fsc_inready got %b want 0", InReady); end
    @(negedge Clk);
    Flush = 1'b0; InValid = 1'b0;
    vectors++; if (OutValid !== 1'b0)     begin miscompares++; $display("FAIL fsc_outvalid got %b want 0", OutValid); end
    vectors++; if (Inst !== 32'h00B50533) begin miscompares++; $display("FAIL fsc_inst got %h want 00b50533", Inst); end
    vectors++; if (ImmSel !== 3'b111)     begin miscompares++; $display("FAIL fsc_immsel got %b want 111", ImmSel); end
    @(negedge Clk);
    vectors++; if (OutValid !== 1'b0)     begin miscompares++; $display("FAIL fsc_after_outvalid got %b want 0", OutValid); end
  endtask

  task automatic test_async_reset();
    @(negedge Clk);
    OutReady = 1'b0; InValid = 1'b1; InInst = 32'h0000006F;
    @(negedge Clk);
    InValid = 1'b0;
    vectors++; if (ImmSel !== 3'b110 || OutValid !== 1'b1) begin
      miscompares++; $display("FAIL ar_setup immsel=%b outvalid=%b want 110 1", ImmSel, OutValid);
    end
    #2;
    Rst = 1'b1;
    #1;
    vectors++; if (OutValid !== 1'b0) begin miscompares++; $display("FAIL ar_outvalid got %b want 0", OutValid); end
    vectors++; if (ImmSel !== 3'b111) begin miscompares++; $display("FAIL ar_immsel got %b want 111", ImmSel); end
    vectors++; if (Inst !== 32'h0)    begin miscompares++; $display("FAIL ar_inst got %h want 0", Inst); end
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    vectors++; if (InReady !== 1'b1)  begin miscompares++; $display("FAIL ar_inready got %b want 1", InReady); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_trap();
    test_flush_same_cycle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_decode_ctrl.md
# imm_decode_ctrl

Decode-stage controller that sits between instruction fetch and execute and sequences the immediate generator. It accepts instructions over a valid/ready handshake and classifies the opcode into the 3-bit immediate-select code. It holds the instruction and select in a one-entry pipeline register that drives the immediate generator's `Inst`/`ImmSel` inputs and the execute stage. Illegal encodings are trapped and the stage is frozen until a flush.

## Interface
- `WIDTH_INST_LENGTH`, 32: instruction width.
- `WIDTH_SEL_LENGTH`, 3: immediate-select width.
- `Clk` input 1: single clock, rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `InInst` input 32: instruction from fetch.
- `InValid` input 1: fetch offers `InInst`.
- `InReady` output 1: stage accepts this cycle.
- `Flush` input 1: discard held instruction, clear trap.
- `OutReady` input 1: execute consumes this cycle.
- `OutValid` output 1: held instruction valid for execute.
- `Inst` output 32: held instruction, to immediate generator and execute.
- `ImmSel` output 3: select code to immediate generator.
- `UsesImm` output 1: held instruction consumes the immediate.
- `Trap` output 1: illegal instruction captured, stage frozen.
- `TrapInst` output 32: offending encoding.

## Operation
- States: EMPTY, VALID, TRAP.
- Accept when `InValid && InReady`.
- `InReady` = (EMPTY) or (VALID and `OutReady`); 0 in TRAP.
- Transitions:
  - EMPTY: accept of a legal instruction -> VALID; accept of an illegal instruction -> TRAP.
  - VALID: `OutReady` with no accept -> EMPTY; `OutReady` with accept -> VALID (legal) or TRAP (illegal); no `OutReady` -> hold.
  - TRAP: hold until `Flush`.
- `Flush` has highest priority from any state -> EMPTY on that edge. A same-cycle `InValid` is not accepted (`InReady` is forced to 0 while `Flush`=1). Flush clears `Trap`, `TrapInst`, and `OutValid`.
- Classification on opcode `InInst[6:0]`:
  - 0000011 load -> `ImmSel`=000.
  - 1100111 JALR -> 000.
  - 0010011 OP-IMM:
    - funct3 001 or 101 -> 010.
    - otherwise -> 000.
  - 0100011 store -> 011.
  - 1100011 branch -> 100.
  - 0110111 LUI and 0010111 AUIPC -> 101.
  - 1101111 JAL -> 110.
  - 1110011 SYSTEM:
    - funct3 != 000 (CSR, address field) -> 001.
    - funct3 000 -> 111 with `UsesImm`=0.
  - 0110011 R-type and 0001111 FENCE -> 111 with `UsesImm`=0.
  - All listed immediate forms set `UsesImm`=1.
- Illegal if any of:
  - `InInst[1:0]` != 11.
  - Opcode not in the list above.
  - Branch funct3 of 010 or 011.
  - OP-IMM funct3 001 with `InInst[31:25]` != 0000000.
  - OP-IMM funct3 101 with `InInst[31:25]` not 0000000 or 0100000.
- On an illegal accept: `TrapInst` <= `InInst`, `Trap`=1, `OutValid`=0. The illegal instruction is never presented to execute.
- `Inst`, `ImmSel`, and `UsesImm` update only on a legal accept and hold otherwise, including when EMPTY.

## Timing
- Reset values:
  - state EMPTY.
  - `OutValid`=0, `Trap`=0.
  - `Inst`=0, `TrapInst`=0.
  - `ImmSel`=111, `UsesImm`=0.
  - `InReady`=1 once `Rst` deasserts.
- Reset asserted mid-transfer drops the held instruction immediately (asynchronous).
- Latency: an instruction accepted at edge N is presented with `OutValid`=1 after edge N.
- Throughput: one instruction per cycle under continuous `OutReady`=1.
- `InReady` is combinational from state, `OutReady`, and `Flush`. No other combinational input-to-output path exists.
- All registered outputs change only on `Clk` rising edges or `Rst`.
- Backpressure: `OutValid`=1 with `OutReady`=0 holds `Inst`/`ImmSel` stable and `InReady`=0.

## Test plan
- Reset, then stream 0x00500093 (ADDI), 0x00209113 (SLLI), 0x00112223 (SW) with `OutReady`=1 -> one per cycle, `ImmSel` = 000, 010, 011, each 1 cycle after accept, `UsesImm`=1.
- Present 0xFE000EE3 (BEQ), 0x123452B7 (LUI), 0x0000006F (JAL), 0x30002573 (CSRRS) -> `ImmSel` = 100, 101, 110, 001.
- Hold `OutReady`=0 for 3 cycles with 0x00B50533 (ADD) held -> `OutValid`, `Inst`, `ImmSel`=111, `UsesImm`=0 stable. `InReady`=0, and the pending next instruction is accepted on the cycle `OutReady` returns to 1.
- Send 0x40209113 (bad SLLI funct7) -> `Trap`=1, `TrapInst`=0x40209113, `OutValid`=0, `InReady`=0 indefinitely. Assert `Flush` for 1 cycle -> EMPTY, `Trap`=0, `InReady`=1.
- `Flush` in the same cycle as `InValid` while VALID -> held instruction dropped, new instruction not accepted, `OutValid`=0 next cycle.
- Assert `Rst` asynchronously between edges while VALID -> `OutValid`=0 and `ImmSel`=111 before the next edge.
